// File: rtl/redmule_tile_pkg.sv
// Shared constants and types for the fractal synchronisation tree.
// The level width and node level defaults live here so every tile agrees on them.
package redmule_tile_pkg;

  localparam int unsigned FSYNC_LVL_W    = 4;
  localparam int unsigned FSYNC_NODE_LVL = 0;

  typedef enum logic [2:0] {
    FSYNC_IDLE,
    FSYNC_UP_SYNC,
    FSYNC_UP_WAIT,
    FSYNC_WAKE,
    FSYNC_UP_ACK
  } fsync_state_e;

endpackage

// File: rtl/fractal_sync_node_ch.sv
// Per-child request latch: pending flag, captured level, violation flag,
// and the wake line that is held until the child acknowledges it.
module fractal_sync_node_ch
  import redmule_tile_pkg::*;
#(
  parameter int unsigned LVL_W = redmule_tile_pkg::FSYNC_LVL_W
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             clear_i,
  input  logic             sync_i,
  input  logic [LVL_W-1:0] level_i,
  input  logic             ack_i,
  input  logic             busy_i,
  input  logic             start_i,
  input  logic             done_i,
  output logic             pend_o,
  output logic [LVL_W-1:0] lvl_o,
  output logic             viol_o,
  output logic             wake_o
);

  logic             pend_q;
  logic             viol_q;
  logic             wake_q;
  logic             stale_q;
  logic [LVL_W-1:0] lvl_q;

  always_ff @(posedge clk_i) begin
    if (!rst_ni || clear_i) begin
      pend_q  <= 1'b0;
      viol_q  <= 1'b0;
      wake_q  <= 1'b0;
      stale_q <= 1'b0;
      lvl_q   <= '0;
    end else begin
      if (ack_i && wake_q) begin
        wake_q <= 1'b0;
      end
      if (start_i) begin
        wake_q <= 1'b1;
      end
      // A sync seen while a resolution is in flight must survive the
      // end-of-resolution clear so it is flagged at the next one.
      if (done_i) begin
        pend_q  <= sync_i | stale_q;
        viol_q  <= stale_q;
        stale_q <= 1'b0;
        if (sync_i) begin
          lvl_q <= level_i;
        end
      end else if (sync_i) begin
        if (pend_q) begin
          viol_q <= 1'b1;
        end else begin
          pend_q <= 1'b1;
          lvl_q  <= level_i;
        end
        if (busy_i) begin
          stale_q <= 1'b1;
        end
      end
    end
  end

  assign pend_o = pend_q;
  assign lvl_o  = lvl_q;
  assign viol_o = viol_q;
  assign wake_o = wake_q;

endmodule

// File: rtl/fractal_sync_node.sv
// Two-child barrier node: resolves requests at its own level, forwards higher
// ones upstream, and wakes both children with an error flag on mismatch.
module fractal_sync_node
  import redmule_tile_pkg::*;
#(
  parameter int unsigned LVL_W    = redmule_tile_pkg::FSYNC_LVL_W,
  parameter int unsigned NODE_LVL = redmule_tile_pkg::FSYNC_NODE_LVL
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               clear_i,
  input  logic [1:0]         ch_sync_i,
  input  logic [2*LVL_W-1:0] ch_level_i,
  output logic [1:0]         ch_wake_o,
  input  logic [1:0]         ch_ack_i,
  output logic [1:0]         ch_error_o,
  output logic               up_sync_o,
  output logic [LVL_W-1:0]   up_level_o,
  input  logic               up_wake_i,
  input  logic               up_error_i,
  output logic               up_ack_o
);

  localparam logic [LVL_W-1:0] NODE_LVL_V = LVL_W'(NODE_LVL);

  fsync_state_e     state_q;
  logic             err_q;
  logic             fwd_q;
  logic [1:0]       pend;
  logic [1:0]       viol;
  logic [1:0]       wake;
  logic [LVL_W-1:0] lvl [2];
  logic             all_pend;
  logic             lvl_bad;
  logic             lvl_local;
  logic             all_released;
  logic             busy;
  logic             wake_start;
  logic             resolve_done;

  for (genvar gi = 0; gi < 2; gi++) begin : g_ch
    fractal_sync_node_ch #(.LVL_W(LVL_W)) u_ch (
      .clk_i   (clk_i),
      .rst_ni  (rst_ni),
      .clear_i (clear_i),
      .sync_i  (ch_sync_i[gi]),
      .level_i (ch_level_i[gi*LVL_W +: LVL_W]),
      .ack_i   (ch_ack_i[gi]),
      .busy_i  (busy),
      .start_i (wake_start),
      .done_i  (resolve_done),
      .pend_o  (pend[gi]),
      .lvl_o   (lvl[gi]),
      .viol_o  (viol[gi]),
      .wake_o  (wake[gi])
    );
  end

  always_comb begin
    all_pend     = &pend;
    lvl_bad      = (lvl[0] != lvl[1]) || (lvl[0] < NODE_LVL_V) || (|viol);
    lvl_local    = (lvl[0] == NODE_LVL_V);
    busy         = (state_q != FSYNC_IDLE) || all_pend;
    all_released = &(~wake | ch_ack_i);
    wake_start   = ((state_q == FSYNC_IDLE) && all_pend && (lvl_bad || lvl_local)) ||
                   ((state_q == FSYNC_UP_WAIT) && up_wake_i);
    resolve_done = (state_q == FSYNC_WAKE) && all_released;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni || clear_i) begin
      state_q <= FSYNC_IDLE;
      err_q   <= 1'b0;
      fwd_q   <= 1'b0;
    end else begin
      case (state_q)
        FSYNC_IDLE: begin
          if (all_pend) begin
            if (lvl_bad) begin
              err_q   <= 1'b1;
              fwd_q   <= 1'b0;
              state_q <= FSYNC_WAKE;
            end else if (lvl_local) begin
              err_q   <= 1'b0;
              fwd_q   <= 1'b0;
              state_q <= FSYNC_WAKE;
            end else begin
              fwd_q   <= 1'b1;
              state_q <= FSYNC_UP_SYNC;
            end
          end
        end
        FSYNC_UP_SYNC: state_q <= FSYNC_UP_WAIT;
        FSYNC_UP_WAIT: begin
          if (up_wake_i) begin
            err_q   <= up_error_i;
            state_q <= FSYNC_WAKE;
          end
        end
        FSYNC_WAKE: begin
          if (all_released) begin
            err_q   <= 1'b0;
            state_q <= fwd_q ? FSYNC_UP_ACK : FSYNC_IDLE;
          end
        end
        FSYNC_UP_ACK: begin
          fwd_q   <= 1'b0;
          state_q <= FSYNC_IDLE;
        end
        default: state_q <= FSYNC_IDLE;
      endcase
    end
  end

  assign ch_wake_o  = wake;
  assign ch_error_o = wake & {2{err_q}};
  assign up_sync_o  = (state_q == FSYNC_UP_SYNC);
  assign up_level_o = up_sync_o ? lvl[0] : '0;
  assign up_ack_o   = (state_q == FSYNC_UP_ACK);

endmodule
